// File: rtl/servo_frame_scheduler.sv
// Servo frame scheduler: buffers one command pair and applies it with per-frame slew limiting.
// Latency: a command accepted before a frame_tick cycle takes its first step on that tick's edge.
// Backpressure: cmd_ready is low while a command is waiting in the one-entry pending buffer.
module servo_frame_scheduler #(
  parameter int FRAME_CYCLES   = 2000000,
  parameter int MAX_STEP       = 16,
  parameter int SERVO_MIN      = 50,
  parameter int SERVO_MAX      = 100,
  parameter int NEUTRAL        = 75,
  parameter int TIMEOUT_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [10:0] cmd_L,
  input  logic [10:0] cmd_R,
  output logic [10:0] servo_L,
  output logic [10:0] servo_R,
  output logic        frame_tick,
  output logic        failsafe
);

  localparam int IW = (TIMEOUT_FRAMES < 2) ? 1 : $clog2(TIMEOUT_FRAMES + 1);

  localparam logic [20:0]        LAST_CNT = 21'(FRAME_CYCLES - 1);
  localparam logic [10:0]        S_MIN    = 11'(SERVO_MIN);
  localparam logic [10:0]        S_MAX    = 11'(SERVO_MAX);
  localparam logic [10:0]        S_NEU    = 11'(NEUTRAL);
  localparam logic [10:0]        STEP_U   = 11'(MAX_STEP);
  localparam logic signed [11:0] STEP_S   = 12'(MAX_STEP);
  localparam logic [IW-1:0]      IDLE_MAX = IW'(TIMEOUT_FRAMES);

  typedef enum logic {ST_RUN, ST_FAILSAFE} state_t;

  state_t      state_q, state_d;
  logic [20:0] frame_cnt;
  logic        pend_valid;
  logic [10:0] pend_L, pend_R;
  logic [10:0] target_L, target_R;
  logic [10:0] eff_L, eff_R;
  logic [IW-1:0] idle_q, idle_d;
  logic        accept;

  // Limit a raw command to the legal servo range.
  function automatic logic [10:0] clamp(input logic [10:0] v);
    if (v < S_MIN)      return S_MIN;
    else if (v > S_MAX) return S_MAX;
    else                return v;
  endfunction

  // Move cur toward tgt by at most MAX_STEP; 12-bit signed difference so nothing wraps.
  function automatic logic [10:0] slew(input logic [10:0] cur, input logic [10:0] tgt);
    logic signed [11:0] d;
    d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (d > STEP_S)       return cur + STEP_U;
    else if (d < -STEP_S) return cur - STEP_U;
    else                  return tgt;
  endfunction

  assign frame_tick = (frame_cnt == LAST_CNT);
  assign cmd_ready  = !pend_valid;
  assign accept     = cmd_valid && cmd_ready;

  // Frame counter: 0..FRAME_CYCLES-1, wrapping after the tick cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_cnt <= '0;
    else      frame_cnt <= frame_tick ? 21'd0 : frame_cnt + 21'd1;
  end

  // Pending buffer: filled on acceptance, drained at the tick it is applied on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_L     <= S_NEU;
      pend_R     <= S_NEU;
    end else if (accept) begin
      pend_valid <= 1'b1;
      pend_L     <= clamp(cmd_L);
      pend_R     <= clamp(cmd_R);
    end else if (frame_tick) begin
      pend_valid <= 1'b0;
    end
  end

  // Effective target for this tick and the next idle-frame count.
  always_comb begin
    eff_L  = target_L;
    eff_R  = target_R;
    idle_d = idle_q;
    if (pend_valid) begin
      eff_L  = pend_L;
      eff_R  = pend_R;
      idle_d = '0;
    end else begin
      if (state_q == ST_FAILSAFE) begin
        eff_L = S_NEU;
        eff_R = S_NEU;
      end
      idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + IW'(1);
    end
  end

  // Targets, slewed outputs and idle counter update only on the tick edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target_L <= S_NEU;
      target_R <= S_NEU;
      servo_L  <= S_NEU;
      servo_R  <= S_NEU;
      idle_q   <= '0;
    end else if (frame_tick) begin
      target_L <= eff_L;
      target_R <= eff_R;
      servo_L  <= slew(servo_L, eff_L);
      servo_R  <= slew(servo_R, eff_R);
      idle_q   <= idle_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_FAILSAFE;
    else      state_q <= state_d;
  end

  // FSM next state: a fresh command always returns to RUN; idling out drops to FAILSAFE.
  always_comb begin
    state_d = state_q;
    if (frame_tick) begin
      if (pend_valid)
        state_d = ST_RUN;
      else if (state_q == ST_RUN && idle_d == IDLE_MAX)
        state_d = ST_FAILSAFE;
    end
  end

  // FSM outputs.
  always_comb begin
    failsafe = (state_q == ST_FAILSAFE);
  end

endmodule

// File: doc/servo_frame_scheduler.md
SERVO_FRAME_SCHEDULER -- requirements
Module: servo_frame_scheduler

Interface
REQ-001 Parameter FRAME_CYCLES, default 2000000, gives the servo frame length in clk cycles (20 ms at 100 MHz).
REQ-002 Parameter MAX_STEP, default 16, gives the maximum change of each servo output per frame.
REQ-003 Parameter SERVO_MIN, default 50, gives the lowest legal servo command (1.0 ms in 20 us units).
REQ-004 Parameter SERVO_MAX, default 100, gives the highest legal servo command (2.0 ms).
REQ-005 Parameter NEUTRAL, default 75, gives the failsafe/reset servo command (1.5 ms).
REQ-006 Parameter TIMEOUT_FRAMES, default 10, gives the number of frames without a command before failsafe.
REQ-007 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-009 Port cmd_valid, input, 1 bit: a new servo command pair is offered.
REQ-010 Port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-011 Port cmd_L, input, 11 bits: requested left servo command.
REQ-012 Port cmd_R, input, 11 bits: requested right servo command.
REQ-013 Port servo_L, output, 11 bits: registered left command to the PWM generator.
REQ-014 Port servo_R, output, 11 bits: registered right command to the PWM generator.
REQ-015 Port frame_tick, output, 1 bit: one-cycle pulse marking the last cycle of each frame.
REQ-016 Port failsafe, output, 1 bit: high while the block is in state FAILSAFE.

Function
REQ-017 Frame counter (21 bits): counts 0..FRAME_CYCLES-1, then wraps to 0; frame_tick = 1 exactly when the count equals FRAME_CYCLES-1.
REQ-018 Pending buffer: one entry, holding pend_L, pend_R and pend_valid; cmd_ready = !pend_valid.
REQ-019 Acceptance: on a cycle with cmd_valid && cmd_ready, cmd_L/cmd_R are clamped to [SERVO_MIN, SERVO_MAX], stored in the pending buffer, and pend_valid is set.
REQ-020 Acceptance on the frame_tick cycle: the command is stored in the pending buffer and takes effect at the next frame_tick, not the current one.
REQ-021 Effective target at frame_tick:
  - pending values if pend_valid = 1 (pend_valid clears on the same edge);
  - else NEUTRAL if in FAILSAFE;
  - else the last applied target.
REQ-022 Slew at frame_tick, per channel independently, with d = target - output:
  - |d| <= MAX_STEP: output = target;
  - otherwise output moves by MAX_STEP toward target.
  - Arithmetic is 12-bit signed, with no wrap.
REQ-023 servo_L/servo_R change only on the edge that ends a frame_tick cycle and hold their value at all other times.
REQ-024 State RUN -> FAILSAFE: at a frame_tick with pend_valid = 0, when the idle-frame counter reaches TIMEOUT_FRAMES after incrementing.
REQ-025 State FAILSAFE -> RUN: at any frame_tick with pend_valid = 1.
REQ-026 Idle-frame counter:
  - clears at any frame_tick that applies a pending command;
  - increments at other frame_ticks;
  - saturates at TIMEOUT_FRAMES.
REQ-027 In FAILSAFE, outputs slew toward NEUTRAL at MAX_STEP per frame, never jumping.
REQ-028 Latency: a command accepted at least one cycle before a frame_tick produces its first output step on that frame_tick's edge.

Reset
REQ-029 While rst = 0, the following hold asynchronously:
  - frame counter = 0;
  - pend_valid = 0, cmd_ready = 1;
  - servo_L = servo_R = NEUTRAL, target = NEUTRAL;
  - idle-frame counter = 0;
  - state = FAILSAFE, failsafe = 1;
  - frame_tick = 0.
REQ-030 Reset asserted mid-frame or with a pending command discards that command; after release, the first frame_tick occurs FRAME_CYCLES cycles later.

Verification (FRAME_CYCLES=100, MAX_STEP=16, TIMEOUT_FRAMES=3, SERVO_MIN=50, SERVO_MAX=100, NEUTRAL=75)
REQ-031 Reset release, no commands -> frame_tick pulses every 100 cycles; servo_L = servo_R = 75, failsafe = 1 throughout.
REQ-032 Accept cmd_L=100, cmd_R=60 mid-frame:
  - cmd_ready drops the next cycle;
  - at successive ticks, servo_L = 91, then 100, and servo_R = 60;
  - failsafe falls at the first tick;
  - cmd_ready returns to 1 after that tick.
REQ-033 cmd_L=2047, cmd_R=0 accepted -> clamped targets 100 and 50; outputs never exceed [50, 100].
REQ-034 Command accepted on the frame_tick cycle -> outputs unchanged at that tick and step at the following tick.
REQ-035 After one command (L=R=100, settled), no further commands:
  - failsafe rises at the 3rd idle tick;
  - outputs then step 100 -> 84 -> 75.
REQ-036 rst pulsed low while pend_valid = 1 and the outputs are at 90 -> outputs are 75 immediately, cmd_ready = 1, and the pending command is never applied.
